// File: rtl/gate_pkg.sv
// Shared types for the gate sensor front end: FSM state encoding and
// the {a,b} filtered sensor codes.
package gate_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EN_A,
      EN_AB,
      EN_B,
      EX_B,
      EX_BA,
      EX_A,
      WAIT_CLR
   } gate_state_t;

   localparam logic [1:0] S_NONE = 2'b00;
   localparam logic [1:0] S_B    = 2'b01;
   localparam logic [1:0] S_A    = 2'b10;
   localparam logic [1:0] S_AB   = 2'b11;

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a hold-time debounce filter for one
// photo sensor.
module sensor_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic filt_o
);

   localparam int unsigned     CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

   logic          s1_q;
   logic          s2_q;
   logic          filt_q;
   logic          filt_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         filt_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         s1_q   <= raw_i;
         s2_q   <= s1_q;
         filt_q <= filt_d;
         cnt_q  <= cnt_d;
      end
   end

   // Counter only runs while the synchronized value disagrees with filt.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (s2_q != filt_q) begin
         if (cnt_q == CNT_LAST) begin
            filt_d = s2_q;
         end else begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   assign filt_o = filt_q;

endmodule

// File: rtl/gate_sensor_fsm.sv
// Gate front end: debounces the outer (a) and inner (b) beams and decodes
// complete entry/exit sequences into one-cycle incr/decr/err pulses.
module gate_sensor_fsm
   import gate_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic a_raw,
   input  logic b_raw,
   output logic incr,
   output logic decr,
   output logic err,
   output logic busy,
   output logic a_filt,
   output logic b_filt
);

   logic        a_f;
   logic        b_f;
   logic [1:0]  ab;

   gate_state_t state_q, state_d;
   logic        incr_q, incr_d;
   logic        decr_q, decr_d;
   logic        err_q, err_d;
   logic        busy_q;

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
      .clk_i  (clk),
      .rst_i  (reset),
      .raw_i  (a_raw),
      .filt_o (a_f)
   );

   sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
      .clk_i  (clk),
      .rst_i  (reset),
      .raw_i  (b_raw),
      .filt_o (b_f)
   );

   assign ab = {a_f, b_f};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         incr_q  <= 1'b0;
         decr_q  <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         incr_q  <= incr_d;
         decr_q  <= decr_d;
         err_q   <= err_d;
         busy_q  <= (state_d != IDLE);
      end
   end

   // Pulses are produced only on the transition itself, so a held input
   // never re-fires them.
   always_comb begin
      state_d = state_q;
      incr_d  = 1'b0;
      decr_d  = 1'b0;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            case (ab)
               S_A:     state_d = EN_A;
               S_B:     state_d = EX_B;
               S_AB:    begin state_d = WAIT_CLR; err_d = 1'b1; end
               default: ;
            endcase
         end
         EN_A: begin
            case (ab)
               S_AB:    state_d = EN_AB;
               S_NONE:  state_d = IDLE;
               S_B:     begin state_d = WAIT_CLR; err_d = 1'b1; end
               default: ;
            endcase
         end
         EN_AB: begin
            case (ab)
               S_B:     state_d = EN_B;
               S_A:     state_d = EN_A;
               S_NONE:  begin state_d = WAIT_CLR; err_d = 1'b1; end
               default: ;
            endcase
         end
         EN_B: begin
            case (ab)
               S_NONE:  begin state_d = IDLE; incr_d = 1'b1; end
               S_AB:    state_d = EN_AB;
               S_A:     begin state_d = WAIT_CLR; err_d = 1'b1; end
               default: ;
            endcase
         end
         EX_B: begin
            case (ab)
               S_AB:    state_d = EX_BA;
               S_NONE:  state_d = IDLE;
               S_A:     begin state_d = WAIT_CLR; err_d = 1'b1; end
               default: ;
            endcase
         end
         EX_BA: begin
            case (ab)
               S_A:     state_d = EX_A;
               S_B:     state_d = EX_B;
               S_NONE:  begin state_d = WAIT_CLR; err_d = 1'b1; end
               default: ;
            endcase
         end
         EX_A: begin
            case (ab)
               S_NONE:  begin state_d = IDLE; decr_d = 1'b1; end
               S_AB:    state_d = EX_BA;
               S_B:     begin state_d = WAIT_CLR; err_d = 1'b1; end
               default: ;
            endcase
         end
         WAIT_CLR: begin
            if (ab == S_NONE) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      incr   = incr_q;
      decr   = decr_q;
      err    = err_q;
      busy   = busy_q;
      a_filt = a_f;
      b_filt = b_f;
   end

endmodule

// File: doc/gate_sensor_fsm.md
Name: gate_sensor_fsm

Overview:
Front-end stage of the parking lot occupancy datapath. Takes two raw photo-sensor inputs at the gate: a is the outer beam and b is the inner beam. It synchronizes and debounces them, then runs a sequence FSM that recognizes a complete car entry or exit. Its one-cycle incr/decr pulses drive the occupancy counter directly.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized samples a sensor must hold a new value before its filtered value changes; legal range 1..255.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
a_raw  input  1  outer sensor, 1 = beam blocked, asynchronous to clk
b_raw  input  1  inner sensor, 1 = beam blocked, asynchronous to clk
incr  output  1  one-cycle pulse: a complete entry was recognized
decr  output  1  one-cycle pulse: a complete exit was recognized
err  output  1  one-cycle pulse: an illegal sensor transition was seen
busy  output  1  FSM is not in IDLE
a_filt  output  1  debounced outer sensor, for LEDs
b_filt  output  1  debounced inner sensor, for LEDs

Behaviour:
- Reset (asynchronous, active-high), including reset asserted mid-sequence:
  - all synchronizer flops, filtered values and debounce counters go to 0;
  - the FSM goes to IDLE;
  - incr, decr, err, busy, a_filt and b_filt read 0 immediately, with no pulse emitted.
- Synchronizer:
  - two-flop chain per sensor; s2 is the second stage.
- Debounce, per sensor and independent:
  - counter width is $clog2(DEBOUNCE_CYCLES+1);
  - while s2 == filt, the counter is held at 0;
  - while s2 != filt, the counter increments each cycle;
  - on the edge where s2 != filt and the counter == DEBOUNCE_CYCLES-1: filt <= s2 and the counter is cleared.
- Latency:
  - a raw change captured at edge 0 reaches filt at edge DEBOUNCE_CYCLES+1;
  - the FSM reacts at edge DEBOUNCE_CYCLES+2.
- FSM:
  - input is the filtered pair {a_filt, b_filt}, written "ab" below; registered outputs.
  - States: IDLE, EN_A, EN_AB, EN_B, EX_B, EX_BA, EX_A, WAIT_CLR.
  - Any state whose input is unchanged stays where it is.
  - IDLE: 10 -> EN_A; 01 -> EX_B; 11 -> WAIT_CLR with err.
  - EN_A: 11 -> EN_AB; 00 -> IDLE (car backed out, no pulse); 01 -> WAIT_CLR with err.
  - EN_AB: 01 -> EN_B; 10 -> EN_A; 00 -> WAIT_CLR with err.
  - EN_B: 00 -> IDLE with incr; 11 -> EN_AB; 10 -> WAIT_CLR with err.
  - EX_B: 11 -> EX_BA; 00 -> IDLE (no pulse); 10 -> WAIT_CLR with err.
  - EX_BA: 10 -> EX_A; 01 -> EX_B; 00 -> WAIT_CLR with err.
  - EX_A: 00 -> IDLE with decr; 11 -> EX_BA; 01 -> WAIT_CLR with err.
  - WAIT_CLR: 00 -> IDLE; any other value stays.
- Output pulses:
  - incr, decr and err are registered;
  - each is asserted for exactly the cycle following the transition edge;
  - at most one is high in any cycle, and none re-fires while the input is held.
- busy is registered and equals (state != IDLE).
- After reset release with sensors already blocked, the filtered values rise normally and the FSM follows the table (for example, 11 gives err and WAIT_CLR).
- The block has no knowledge of lot capacity; saturation is the counter's job.

Decomposition:
- Package gate_pkg:
  - typedef enum logic [2:0] gate_state_t covering the 8 states;
  - localparams for the sensor codes S_NONE=2'b00, S_B=2'b01, S_A=2'b10, S_AB=2'b11.
- Sub-module sensor_debounce: synchronizer plus debounce counter for one sensor, parameterized by DEBOUNCE_CYCLES. It is instantiated twice.

Test Plan:
1. DEBOUNCE_CYCLES=1; raw ab steps 00->10->11->01->00, each held 5 cycles -> exactly one incr pulse, 3 cycles after raw returns to 00; decr=err=0; busy low afterwards.
2. DEBOUNCE_CYCLES=1; ab steps 00->01->11->10->00 -> exactly one decr pulse; repeating it 3 times -> 3 decr pulses, each 1 cycle wide.
3. DEBOUNCE_CYCLES=1; ab steps 00->10->11->10->00 (reversal) -> no incr, decr or err; busy high during the sequence, then low.
4. DEBOUNCE_CYCLES=1; ab jumps 00->11 -> err for 1 cycle and busy stays high; ab then goes 01 -> still WAIT_CLR; ab then goes 00 -> busy low.
5. DEBOUNCE_CYCLES=4; a_raw toggled with 3-cycle-high glitches -> a_filt stays 0 and busy stays 0; a_raw held high 6 cycles -> a_filt rises 5 edges after capture.
6. DEBOUNCE_CYCLES=1; assert reset asynchronously while in EN_B, between clock edges -> all outputs read 0 before the next edge; no incr after release with ab=00.
